// File: rtl/pipe_hazard_ctrl.sv
// Purpose : pipeline sequencing for a 5-stage core (load-use stall, branch squash, dmem wait, halt drain).
// Latency : outputs are combinational from the state register and the current inputs; state updates on the next clk.
// Backpress: mem_busy freezes every inter-stage register and the PC until the data memory is ready.
//
// Ports:
//   clk, rst (sync, active-low)
//   dec_*     decode-stage operand indices/usage and halt flag
//   ex_*      execute-stage load/write info and taken-branch flush
//   mem_busy  data memory not ready; wb_halt halt reached writeback
//   pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en  pipeline register controls
//   halted    processor halted (sticky until reset)
//   stall_cnt, flush_cnt  saturating performance counters
//
// Build option: define PIPE_PERF_CNT_EN to build the performance counters;
// without it both counter ports read 0 and no counter flops exist.
module pipe_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       dec_rqrd,
  input  logic [2:0]       dec_rs,
  input  logic             dec_use_rqrd,
  input  logic             dec_use_rs,
  input  logic             dec_halt,
  input  logic             ex_mem_read,
  input  logic             ex_write_en,
  input  logic [2:0]       ex_write_reg,
  input  logic             ex_flush,
  input  logic             mem_busy,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_flush,
  output logic             de_en,
  output logic             de_bubble,
  output logic             em_en,
  output logic             mw_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_LU_STALL = 3'd1,
    S_MEM_WAIT = 3'd2,
    S_DRAIN    = 3'd3,
    S_HALTED   = 3'd4
  } state_t;

  // Drain counter must be able to hold DRAIN_CYC+1 (watchdog limit).
  localparam int              DW        = $clog2(DRAIN_CYC + 2);
  localparam logic [DW-1:0]   DRAIN_LIM = DW'(DRAIN_CYC + 1);

  state_t        state, state_nxt;
  logic [DW-1:0] drain_cnt, drain_cnt_nxt, drain_inc;
  logic          lu;
  logic          stall_evt;
  logic          flush_evt;

  // Load-use: the only hazard forwarding cannot cover.
  assign lu = ex_mem_read & ex_write_en &
              ((dec_use_rqrd & (dec_rqrd == ex_write_reg)) |
               (dec_use_rs   & (dec_rs   == ex_write_reg)));

  assign drain_inc = drain_cnt + 1'b1;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_cnt_nxt;
    end
  end

  // Next-state logic. RUN, LU_STALL and MEM_WAIT (once memory is ready)
  // all evaluate the same priority chain: mem_busy > ex_flush > lu > dec_halt.
  always_comb begin
    state_nxt     = state;
    drain_cnt_nxt = '0;
    stall_evt     = 1'b0;
    flush_evt     = 1'b0;
    case (state)
      S_RUN, S_LU_STALL, S_MEM_WAIT: begin
        if (mem_busy) begin
          state_nxt = S_MEM_WAIT;
          stall_evt = 1'b1;
        end else if (ex_flush) begin
          // Flush squashes the decode instruction, so a coincident lu or halt is dropped.
          state_nxt = S_RUN;
          flush_evt = 1'b1;
        end else if (lu) begin
          state_nxt = S_LU_STALL;
          stall_evt = 1'b1;
        end else if (dec_halt) begin
          state_nxt = S_DRAIN;
        end else begin
          state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        drain_cnt_nxt = drain_cnt;
        if (!mem_busy) begin
          if (ex_flush) begin
            // Halt was on the wrong path.
            state_nxt     = S_RUN;
            flush_evt     = 1'b1;
            drain_cnt_nxt = '0;
          end else if (wb_halt) begin
            state_nxt     = S_HALTED;
            drain_cnt_nxt = '0;
          end else begin
            drain_cnt_nxt = drain_inc;
            // Watchdog: halt never showed up in writeback.
            if (drain_inc == DRAIN_LIM) state_nxt = S_HALTED;
          end
        end
      end
      S_HALTED: state_nxt = S_HALTED;
      default:  state_nxt = S_RUN;
    endcase
  end

  // Output logic
  always_comb begin
    pc_en     = 1'b0;
    fd_en     = 1'b0;
    fd_flush  = 1'b0;
    de_en     = 1'b0;
    de_bubble = 1'b0;
    em_en     = 1'b0;
    mw_en     = 1'b0;
    halted    = 1'b0;
    if (!rst) begin
      fd_flush  = 1'b1;
      de_bubble = 1'b1;
    end else begin
      case (state)
        S_RUN, S_LU_STALL, S_MEM_WAIT: begin
          if (!mem_busy) begin
            pc_en = 1'b1;
            fd_en = 1'b1;
            de_en = 1'b1;
            em_en = 1'b1;
            mw_en = 1'b1;
            if (ex_flush) begin
              fd_flush  = 1'b1;
              de_bubble = 1'b1;
            end else if (lu) begin
              // Hold PC and fetch/decode, insert one bubble into execute.
              pc_en     = 1'b0;
              fd_en     = 1'b0;
              de_bubble = 1'b1;
            end
          end
        end
        S_DRAIN: begin
          // A frozen drain leaves every register untouched, flush included.
          if (!mem_busy) begin
            fd_en    = 1'b1;
            fd_flush = 1'b1;
            de_en    = 1'b1;
            em_en    = 1'b1;
            mw_en    = 1'b1;
            if (ex_flush) begin
              // PC must load the branch target.
              pc_en     = 1'b1;
              de_bubble = 1'b1;
            end
          end
        end
        S_HALTED: halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) stall_q <= stall_q + 1'b1;
      if (flush_evt && (flush_q != '1)) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  logic unused_evt;
  assign unused_evt = stall_evt ^ flush_evt;
  assign stall_cnt  = '0;
  assign flush_cnt  = '0;
`endif

endmodule
